// File: rtl/sent_rx_fast_fifo_if.sv
// Bundle of write-side, host-side and status signals for the SENT fast-channel receive FIFO.
interface sent_rx_fast_fifo_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 4
);
  logic              write_enable_rx_i;
  logic [DATA_W-1:0] data_fast_i;
  logic              read_enable_i;
  logic              flush_i;
  logic              clear_flags_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              full_o;
  logic              almost_full_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output write_enable_rx_i, data_fast_i, read_enable_i, flush_i, clear_flags_i,
    input  data_o, valid_o, full_o, almost_full_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  write_enable_rx_i, data_fast_i, read_enable_i, flush_i, clear_flags_i,
    output data_o, valid_o, full_o, almost_full_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sent_rx_fast_fifo.sv
// Show-ahead receive FIFO for decoded SENT fast-channel words, with occupancy count,
// almost-full threshold and sticky overflow/underflow flags.
module sent_rx_fast_fifo #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 12
) (
  input logic             clk_rx,
  input logic             reset_rx,
  sent_rx_fast_fifo_if.slave fifo
);
  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;

  logic valid;
  logic full;
  logic rd_acc;
  logic wr_acc;
  logic mem_we;
  logic ovf_evt;
  logic udf_evt;

  // Full/empty come only from the registered count; a pop frees a slot for a same-edge write.
  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign rd_acc  = fifo.read_enable_i & valid;
  assign wr_acc  = fifo.write_enable_rx_i & (~full | rd_acc);
  assign mem_we  = wr_acc & ~fifo.flush_i & ~reset_rx;
  assign ovf_evt = fifo.write_enable_rx_i & full & ~rd_acc & ~fifo.flush_i;
  assign udf_evt = fifo.read_enable_i & ~valid & ~fifo.flush_i;

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (fifo.flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        if (wr_acc && !rd_acc)      count <= count + 1'b1;
        else if (rd_acc && !wr_acc) count <= count - 1'b1;
      end
      // A new error event outranks a clear request in the same cycle.
      if (ovf_evt)                 ovf <= 1'b1;
      else if (fifo.clear_flags_i) ovf <= 1'b0;
      if (udf_evt)                 udf <= 1'b1;
      else if (fifo.clear_flags_i) udf <= 1'b0;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (mem_we) mem[wr_ptr] <= fifo.data_fast_i;
  end

  assign fifo.data_o        = valid ? mem[rd_ptr] : '0;
  assign fifo.valid_o       = valid;
  assign fifo.full_o        = full;
  assign fifo.almost_full_o = (count >= AFULL_C);
  assign fifo.count_o       = count;
  assign fifo.overflow_o    = ovf;
  assign fifo.underflow_o   = udf;
endmodule

// File: tb/tb_sent_rx_fast_fifo.sv
// Bench for sent_rx_fast_fifo: directed vector table, corner sequences and a randomized run
// against a queue-based model of the FIFO behaviour.
module tb_sent_rx_fast_fifo;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int AFTH   = 12;

  logic clk_rx = 1'b0;
  logic reset_rx;
  always #5 clk_rx = ~clk_rx;

  sent_rx_fast_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sent_rx_fast_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFTH)) dut (
    .clk_rx   (clk_rx),
    .reset_rx (reset_rx),
    .fifo     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] q[$];
  bit m_ovf;
  bit m_udf;

  typedef struct {
    int rst, we, d, re, fl, cf;
    int ev, ed, ec, ef, eaf, eo, eu;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Behavioural model: the FIFO is a queue of words plus two sticky bits.
  task automatic model(input int rst, input int we, input int d, input int re, input int fl,
                       input int cf);
    bit was_empty, was_full, pop, push, ev_o, ev_u;
    if (rst != 0) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      return;
    end
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    pop  = (re != 0) && !was_empty;
    push = (we != 0) && (!was_full || pop);
    ev_o = 0;
    ev_u = 0;
    if (fl != 0) begin
      q.delete();
    end else begin
      ev_o = (we != 0) && was_full && !pop;
      ev_u = (re != 0) && was_empty;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(DATA_W'(d));
    end
    if (ev_o) m_ovf = 1; else if (cf != 0) m_ovf = 0;
    if (ev_u) m_udf = 1; else if (cf != 0) m_udf = 0;
  endtask

  task automatic step(input int rst, input int we, input int d, input int re, input int fl,
                      input int cf);
    reset_rx              = (rst != 0);
    bus.write_enable_rx_i = (we != 0);
    bus.data_fast_i       = DATA_W'(d);
    bus.read_enable_i     = (re != 0);
    bus.flush_i           = (fl != 0);
    bus.clear_flags_i     = (cf != 0);
    @(posedge clk_rx);
    #1;
    model(rst, we, d, re, fl, cf);
    reset_rx              = 1'b0;
    bus.write_enable_rx_i = 1'b0;
    bus.read_enable_i     = 1'b0;
    bus.flush_i           = 1'b0;
    bus.clear_flags_i     = 1'b0;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".valid"}, 32'(bus.valid_o), 32'(n > 0));
    chk({tag, ".data"},  32'(bus.data_o),  (n > 0) ? 32'(q[0]) : 32'd0);
    chk({tag, ".count"}, 32'(bus.count_o), 32'(n));
    chk({tag, ".full"},  32'(bus.full_o),  32'(n == DEPTH));
    chk({tag, ".afull"}, 32'(bus.almost_full_o), 32'(n >= AFTH));
    chk({tag, ".ovf"},   32'(bus.overflow_o),  32'(m_ovf));
    chk({tag, ".udf"},   32'(bus.underflow_o), 32'(m_udf));
  endtask

  initial begin
    reset_rx              = 1'b1;
    bus.write_enable_rx_i = 1'b0;
    bus.data_fast_i       = '0;
    bus.read_enable_i     = 1'b0;
    bus.flush_i           = 1'b0;
    bus.clear_flags_i     = 1'b0;

    //            rst we  d      re fl cf   v  data   cnt f af o  u
    vecs[0]  = '{1, 0, 'h000, 0, 0, 0,   0, 'h000, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 'h123, 0, 0, 0,   1, 'h123, 1, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 'h000, 1, 0, 0,   0, 'h000, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 'h000, 1, 0, 0,   0, 'h000, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 0, 'h000, 0, 0, 1,   0, 'h000, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 1, 'h055, 1, 0, 0,   1, 'h055, 1, 0, 0, 0, 1};
    vecs[6]  = '{0, 1, 'h0AA, 0, 0, 0,   1, 'h055, 2, 0, 0, 0, 1};
    vecs[7]  = '{0, 1, 'h3C3, 1, 1, 0,   0, 'h000, 0, 0, 0, 0, 1};
    vecs[8]  = '{0, 1, 'h111, 0, 0, 0,   1, 'h111, 1, 0, 0, 0, 1};
    vecs[9]  = '{0, 0, 'h000, 0, 0, 1,   1, 'h111, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 'h000, 1, 0, 0,   0, 'h000, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 'h000, 1, 0, 1,   0, 'h000, 0, 0, 0, 0, 1};
    vecs[12] = '{0, 0, 'h000, 0, 0, 1,   0, 'h000, 0, 0, 0, 0, 0};

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].rst, vecs[i].we, vecs[i].d, vecs[i].re, vecs[i].fl, vecs[i].cf);
      chk({t, ".valid"}, 32'(bus.valid_o),       32'(vecs[i].ev));
      chk({t, ".data"},  32'(bus.data_o),        32'(vecs[i].ed));
      chk({t, ".count"}, 32'(bus.count_o),       32'(vecs[i].ec));
      chk({t, ".full"},  32'(bus.full_o),        32'(vecs[i].ef));
      chk({t, ".afull"}, 32'(bus.almost_full_o), 32'(vecs[i].eaf));
      chk({t, ".ovf"},   32'(bus.overflow_o),    32'(vecs[i].eo));
      chk({t, ".udf"},   32'(bus.underflow_o),   32'(vecs[i].eu));
    end

    // Fill to full, overflow on the 17th write, then drain in order.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, i, 0, 0, 0);
      check_model($sformatf("fill%0d", i));
    end
    chk("fill.full", 32'(bus.full_o), 32'd1);
    step(0, 1, 'hABC, 0, 0, 0);
    check_model("ovf_write");
    chk("ovf.flag", 32'(bus.overflow_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(bus.data_o), 32'(i));
      step(0, 0, 0, 1, 0, 0);
      check_model($sformatf("drain%0d", i));
    end

    // Full with simultaneous write and read: count holds, pointers wrap.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 'h200 + i, 0, 0, 0);
    step(0, 1, 'h7FF, 1, 0, 0);
    check_model("full_rw");
    chk("full_rw.count", 32'(bus.count_o), 32'd16);
    chk("full_rw.ovf", 32'(bus.overflow_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full_rw.last", 32'(bus.data_o), 32'h7FF);
      step(0, 0, 0, 1, 0, 0);
      check_model($sformatf("wrap_drain%0d", i));
    end

    // Reset mid-stream with a write active.
    for (int i = 0; i < 8; i++) step(0, 1, 'h400 + i, 0, 0, 0);
    step(1, 1, 'hFFF, 0, 0, 0);
    check_model("midrst");
    chk("midrst.count", 32'(bus.count_o), 32'd0);
    step(0, 1, 'h321, 0, 0, 0);
    check_model("post_rst_wr");
    step(0, 0, 0, 1, 0, 0);
    check_model("post_rst_rd");

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      int wp, we, re, fl, cf, rst;
      wp  = ((i / 150) % 2 == 0) ? 80 : 35;
      we  = ($urandom_range(99) < wp) ? 1 : 0;
      re  = ($urandom_range(99) < 55) ? 1 : 0;
      fl  = ($urandom_range(199) == 0) ? 1 : 0;
      cf  = (fl == 0 && $urandom_range(19) == 0) ? 1 : 0;
      rst = ($urandom_range(499) == 0) ? 1 : 0;
      step(rst, we, int'($urandom_range(4095)), re, fl, cf);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
